// File: rtl/pipeline_dbg_pkg.sv
// Shared types and constants for the debug register-dump path.
// The optional framing (header + checksum) is enabled with REG_DUMP_FRAME_EN.
package pipeline_dbg_pkg;

    localparam int unsigned DEF_NUM_REGS      = 32;
    localparam int unsigned DEF_BYTES_PER_REG = 4;
    localparam logic [7:0]  FRAME_HDR         = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSend,
        StDone,
        StHdr,
        StCsum
    } dump_state_e;

    // Byte that leaves the word first in the chosen order.
    function automatic logic [7:0] lead_byte(input logic [31:0] w, input bit msb_first);
        return msb_first ? w[31:24] : w[7:0];
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] w, input bit msb_first);
        return msb_first ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Registered valid/ready byte source: loads a 32-bit word (or one single byte)
// and steps it out byte by byte, flagging acceptance of the final byte.
module byte_serializer
    import pipeline_dbg_pkg::*;
#(
    parameter int unsigned BYTES_PER_REG = DEF_BYTES_PER_REG,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        load_single,
    input  logic [31:0] word,
    input  logic [7:0]  single_byte,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accept
);

    localparam int unsigned CW = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_REG - 1);

    logic [31:0]   shreg_q;
    logic [CW-1:0] cnt_q;

    assign last_accept = tx_valid && tx_ready && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg_q  <= shift_out(word, MSB_FIRST);
            tx_data  <= lead_byte(word, MSB_FIRST);
            cnt_q    <= '0;
            tx_valid <= 1'b1;
        end else if (load_single) begin
            // A lone byte is treated as the last byte of its group.
            tx_data  <= single_byte;
            cnt_q    <= LAST;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            if (cnt_q == LAST) begin
                tx_valid <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                tx_data <= lead_byte(shreg_q, MSB_FIRST);
                shreg_q <= shift_out(shreg_q, MSB_FIRST);
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Walks the register file through reg_sel and streams every word as bytes, holding
// halt_req while busy. Define REG_DUMP_FRAME_EN for a 0xA5 header and XOR checksum byte.
module reg_dump_tx
    import pipeline_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
    parameter int unsigned BYTES_PER_REG = DEF_BYTES_PER_REG,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        halt_req,
    output logic        done
);

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    dump_state_e state_q, state_d;
    logic [4:0]  sel_d;
    logic        armed_q;
    logic        load;
    logic        load_single;
    logic [7:0]  single_byte;
    logic        last_accept;
`ifdef REG_DUMP_FRAME_EN
    logic [7:0]  csum_q, csum_d;
`endif

    byte_serializer #(
        .BYTES_PER_REG (BYTES_PER_REG),
        .MSB_FIRST     (MSB_FIRST)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_single (load_single),
        .word        (reg_data),
        .single_byte (single_byte),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .last_accept (last_accept)
    );

    // armed_q masks a start that coincides with the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            reg_sel <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_sel <= sel_d;
            armed_q <= 1'b1;
        end
    end

`ifdef REG_DUMP_FRAME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = reg_sel;
        load        = 1'b0;
        load_single = 1'b0;
        single_byte = '0;
`ifdef REG_DUMP_FRAME_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start && armed_q) begin
                    sel_d = '0;
`ifdef REG_DUMP_FRAME_EN
                    csum_d      = '0;
                    load_single = 1'b1;
                    single_byte = FRAME_HDR;
                    state_d     = StHdr;
`else
                    state_d     = StLatch;
`endif
                end
            end
            StLatch: begin
                load    = 1'b1;
                state_d = StSend;
            end
            StSend: begin
`ifdef REG_DUMP_FRAME_EN
                if (tx_valid && tx_ready) csum_d = csum_q ^ tx_data;
`endif
                if (last_accept) begin
                    if (reg_sel == LAST_REG) begin
`ifdef REG_DUMP_FRAME_EN
                        // csum_d already folds in the byte accepted this cycle.
                        load_single = 1'b1;
                        single_byte = csum_d;
                        state_d     = StCsum;
`else
                        state_d     = StDone;
`endif
                    end else begin
                        sel_d   = reg_sel + 5'd1;
                        state_d = StLatch;
                    end
                end
            end
`ifdef REG_DUMP_FRAME_EN
            StHdr: begin
                if (last_accept) state_d = StLatch;
            end
            StCsum: begin
                if (last_accept) state_d = StDone;
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign halt_req = busy;
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: an MSB-first and an LSB-first instance share
// start/tx_ready; expected byte streams come from a word-level model of the dump.
module tb_reg_dump_tx;

    localparam int unsigned NREG = 32;
`ifdef REG_DUMP_FRAME_EN
    localparam int unsigned HDR_N     = 1;
    localparam int unsigned EXTRA_LAT = 2;
`else
    localparam int unsigned HDR_N     = 0;
    localparam int unsigned EXTRA_LAT = 0;
`endif
    localparam int unsigned TOTAL = NREG * 4 + 2 * HDR_N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] regs [NREG];

    logic [4:0]  reg_sel, l_reg_sel;
    logic [31:0] reg_data, l_reg_data;
    logic [7:0]  tx_data, l_tx_data;
    logic        tx_valid, l_tx_valid;
    logic        busy, l_busy, halt_req, l_halt_req, done, l_done;

    assign reg_data   = regs[reg_sel];
    assign l_reg_data = regs[l_reg_sel];

    reg_dump_tx #(.NUM_REGS(NREG), .BYTES_PER_REG(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reg_sel(reg_sel), .reg_data(reg_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .halt_req(halt_req), .done(done)
    );

    reg_dump_tx #(.NUM_REGS(NREG), .BYTES_PER_REG(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .reg_sel(l_reg_sel), .reg_data(l_reg_data),
        .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(tx_ready), .busy(l_busy),
        .halt_req(l_halt_req), .done(l_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    int n_vec = 0;
    int n_err = 0;
    int acc_total = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int lat_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every register word split into bytes in the instance's order.
    task automatic push_dump();
        logic [7:0] bm, bl;
`ifdef REG_DUMP_FRAME_EN
        logic [7:0] cs;
        cs = 8'h00;
        exp_m.push_back(8'hA5);
        exp_l.push_back(8'hA5);
`endif
        for (int r = 0; r < NREG; r++) begin
            for (int b = 0; b < 4; b++) begin
                bm = 8'(regs[r] >> (8 * (3 - b)));
                bl = 8'(regs[r] >> (8 * b));
                exp_m.push_back(bm);
                exp_l.push_back(bl);
`ifdef REG_DUMP_FRAME_EN
                cs = cs ^ bm;
`endif
            end
        end
`ifdef REG_DUMP_FRAME_EN
        exp_m.push_back(cs);
        exp_l.push_back(cs);
`endif
    endtask

    // Monitor: samples 2 time units before each rising edge, when inputs are settled.
    initial begin
        bit pend_m, pend_l;
        logic [7:0] pd_m, pd_l;
        pend_m = 1'b0;
        pend_l = 1'b0;
        pd_m = '0;
        pd_l = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                pend_m = 1'b0;
                pend_l = 1'b0;
            end else begin
                if (pend_m) begin
                    chk("stall_valid_msb", 32'(tx_valid), 32'd1);
                    chk("stall_data_msb", 32'(tx_data), 32'(pd_m));
                end
                if (pend_l) begin
                    chk("stall_valid_lsb", 32'(l_tx_valid), 32'd1);
                    chk("stall_data_lsb", 32'(l_tx_data), 32'(pd_l));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_m.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_byte_msb: got %0h, expected no byte", tx_data);
                    end else begin
                        chk("byte_msb", 32'(tx_data), 32'(exp_m.pop_front()));
                    end
                    chk("halt_busy_msb", {30'd0, busy, halt_req}, 32'd3);
                    acc_total++;
                end
                if (l_tx_valid && tx_ready) begin
                    if (exp_l.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_byte_lsb: got %0h, expected no byte", l_tx_data);
                    end else begin
                        chk("byte_lsb", 32'(l_tx_data), 32'(exp_l.pop_front()));
                    end
                    chk("halt_busy_lsb", {30'd0, l_busy, l_halt_req}, 32'd3);
                end
                pend_m = tx_valid && !tx_ready;
                pd_m   = tx_data;
                pend_l = l_tx_valid && !tx_ready;
                pd_l   = l_tx_data;
                if (done) begin
                    done_cnt++;
                    chk("done_lsb_aligned", 32'(l_done), 32'd1);
                    if (lat_exp != 0) chk("done_latency", 32'(cyc - start_cyc), 32'(lat_exp));
                end
            end
        end
    end

    task automatic do_abort();
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_halt", 32'(halt_req), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_reg_sel", 32'(reg_sel), 32'd0);
        chk("abort_lsb_valid", 32'(l_tx_valid), 32'd0);
        exp_m.delete();
        exp_l.delete();
        lat_exp = 0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("start_at_release_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("idle_after_abort", {30'd0, busy, tx_valid}, 32'd0);
    endtask

    // mode 0: tx_ready held high; 1: random; 2: random plus a 7-cycle stall on byte 13.
    task automatic run_dump(input int mode, input bit poke, input bit abort);
        int base_acc, base_done;
        bit stalled, fin;
        push_dump();
        base_acc  = acc_total;
        base_done = done_cnt;
        stalled   = 1'b0;
        fin       = 1'b0;
        @(negedge clk);
        #1;
        start    = 1'b1;
        tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        lat_exp   = (mode == 0) ? int'(NREG * 5 + EXTRA_LAT) : 0;
        for (int n = 1; n < 4000 && !fin; n++) begin
            @(negedge clk);
            #1;
            start    = poke && (n == 40);
            tx_ready = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
            if (mode == 2 && !stalled && acc_total == base_acc + int'(HDR_N) + 13) begin
                tx_ready = 1'b0;
                stalled  = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    chk("bp_data", 32'(tx_data), 32'hAD);
                    chk("bp_valid", 32'(tx_valid), 32'd1);
                    @(negedge clk);
                    #1;
                end
                tx_ready = 1'b1;
            end
            if (abort && acc_total == base_acc + int'(HDR_N) + 22) begin
                do_abort();
                return;
            end
            if (done_cnt != base_done) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL dump_timeout: got no done, expected done within 4000 cycles");
        end
        chk("busy_dropped", {30'd0, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt - base_done), 32'd1);
        chk("byte_count", 32'(acc_total - base_acc), 32'(TOTAL));
        chk("queue_drained", 32'(exp_m.size() + exp_l.size()), 32'd0);
        lat_exp = 0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halt", 32'(halt_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);

        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("release_start_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("release_still_idle", {30'd0, busy, tx_valid}, 32'd0);

        for (int i = 0; i < NREG; i++) regs[i] = 32'h11111111 * 32'(i % 16);
        run_dump(0, 1'b1, 1'b0);

        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        regs[1] = 32'h12345678;
        regs[3] = 32'hDEADBEEF;
        run_dump(2, 1'b0, 1'b0);

        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        run_dump(1, 1'b0, 1'b1);

        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        run_dump(1, 1'b0, 1'b0);

`ifdef REG_DUMP_FRAME_EN
        for (int i = 0; i < NREG; i++) regs[i] = '0;
        regs[31] = 32'h0000A5FF;
        run_dump(0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
